writeback_arbiter: RTL and testbench

//  Write-side master of the register file: merges ALU results (single-cycle, no backpressure) and load

---
 rtl/writeback_arbiter_pkg.sv | 13 +
 rtl/writeback_arbiter_wb_fifo.sv | 54 +++++
 rtl/writeback_arbiter.sv | 106 ++++++++++
 tb/tb_writeback_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared types and sizes for the register-file write-back path.
package writeback_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// Small synchronous FIFO holding load results until the write port is free.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write master: ALU results take priority, load results are buffered,
// and a pending-load scoreboard flags registers still awaiting load data.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int XLEN          = writeback_arbiter_pkg::XLEN,
  parameter int LD_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] WriteAddr,
  output logic [XLEN-1:0]       WriteData,
  output logic [REG_COUNT-1:0]  pending,
  output logic                  err
);

  wb_entry_t             push_entry;
  wb_entry_t             fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  ld_push;
  logic                  sel_alu;
  logic                  sel_fifo;
  logic                  sel_any;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic [REG_COUNT-1:0]  set_vec;
  logic [REG_COUNT-1:0]  clr_vec;
  logic [REG_COUNT-1:0]  pending_nxt;
  logic                  issue_hazard;
  logic                  alu_hazard;
  logic                  push_hazard;

  assign ld_ready   = !fifo_full;
  assign ld_push    = ld_valid && ld_ready;
  assign push_entry = '{rd: ld_rd, data: ld_data};

  wb_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (ld_push),
    .push_entry (push_entry),
    .pop        (sel_fifo),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  assign sel_alu  = alu_valid;
  assign sel_fifo = !alu_valid && !fifo_empty;
  assign sel_any  = sel_alu || sel_fifo;

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (sel_fifo) begin
      sel_rd   = fifo_head.rd;
      sel_data = fifo_head.data;
    end
  end

  // A new issue to the same rd as a retiring load keeps the bit set.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (ld_issue && ld_issue_rd != '0) set_vec[ld_issue_rd] = 1'b1;
    if (sel_fifo) clr_vec[fifo_head.rd] = 1'b1;
    pending_nxt    = (pending & ~clr_vec) | set_vec;
    pending_nxt[0] = 1'b0;
  end

  assign issue_hazard = ld_issue && (ld_issue_rd != '0) && pending[ld_issue_rd]
                        && !clr_vec[ld_issue_rd];
  assign alu_hazard   = alu_valid && pending[alu_rd];
  // Loads targeting x0 are never tracked, so their results are not violations.
  assign push_hazard  = ld_push && (ld_rd != '0) && !pending[ld_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      we        <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
      pending   <= '0;
      err       <= 1'b0;
    end else begin
      we <= sel_any && (sel_rd != '0);
      if (sel_any) begin
        WriteAddr <= sel_rd;
        WriteData <= sel_data;
      end
      pending <= pending_nxt;
      err     <= err || issue_hazard || alu_hazard || push_hazard;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with hand-computed expectations.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        we;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [31:0] pending;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .we          (we),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .pending     (pending),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ld_issue    = 1'b0;
    ld_issue_rd = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check_val("rst_we",      32'(we),        32'h0);
    check_val("rst_addr",    32'(WriteAddr), 32'h0);
    check_val("rst_data",    WriteData,      32'h0);
    check_val("rst_pending", pending,        32'h0);
    check_val("rst_err",     32'(err),       32'h0);
    check_val("rst_ready",   32'(ld_ready),  32'h1);
    rst = 1'b0;

    // ALU stream
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
    step();
    check_val("alu0_we",   32'(we),        32'h1);
    check_val("alu0_addr", 32'(WriteAddr), 32'd5);
    check_val("alu0_data", WriteData,      32'h11);
    alu_rd = 5'd6; alu_data = 32'h22;
    step();
    check_val("alu1_we",   32'(we),        32'h1);
    check_val("alu1_addr", 32'(WriteAddr), 32'd6);
    check_val("alu1_data", WriteData,      32'h22);
    alu_valid = 1'b0;
    step();
    check_val("alu_idle_we", 32'(we), 32'h0);

    // Load under ALU pressure
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    step();
    ld_issue = 1'b0;
    check_val("ld7_pend_set", pending, 32'h0000_0080);
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h1;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hAA;
    step();
    ld_valid = 1'b0;
    check_val("press0_addr", 32'(WriteAddr), 32'd10);
    step();
    check_val("press1_pend", pending, 32'h0000_0080);
    step();
    check_val("press2_addr", 32'(WriteAddr), 32'd10);
    alu_valid = 1'b0;
    step();
    check_val("ld7_we",       32'(we),        32'h1);
    check_val("ld7_addr",     32'(WriteAddr), 32'd7);
    check_val("ld7_data",     WriteData,      32'hAA);
    check_val("ld7_pend_clr", pending,        32'h0);
    step();
    check_val("ld7_after_we", 32'(we),  32'h0);
    check_val("ld7_err",      32'(err), 32'h0);

    // FIFO full and drain order
    for (int r = 11; r <= 13; r++) begin
      ld_issue = 1'b1; ld_issue_rd = 5'(r);
      step();
    end
    ld_issue = 1'b0;
    check_val("full_pend", pending, 32'h0000_3800);
    alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h5;
    ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'hB1;
    step();
    check_val("full_rdy1", 32'(ld_ready), 32'h1);
    ld_rd = 5'd12; ld_data = 32'hB2;
    step();
    check_val("full_rdy2", 32'(ld_ready), 32'h0);
    ld_rd = 5'd13; ld_data = 32'hB3;
    step();
    check_val("full_rdy3", 32'(ld_ready),  32'h0);
    check_val("full_alu",  32'(WriteAddr), 32'd14);
    alu_valid = 1'b0;
    step();
    check_val("drain0_addr", 32'(WriteAddr), 32'd11);
    check_val("drain0_data", WriteData,      32'hB1);
    check_val("drain0_rdy",  32'(ld_ready),  32'h1);
    step();
    ld_valid = 1'b0;
    check_val("drain1_addr", 32'(WriteAddr), 32'd12);
    check_val("drain1_data", WriteData,      32'hB2);
    step();
    check_val("drain2_we",   32'(we),        32'h1);
    check_val("drain2_addr", 32'(WriteAddr), 32'd13);
    check_val("drain2_data", WriteData,      32'hB3);
    step();
    check_val("drain_we",   32'(we),  32'h0);
    check_val("drain_pend", pending,  32'h0);
    check_val("drain_err",  32'(err), 32'h0);

    // rd = 0
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    step();
    idle_inputs();
    check_val("x0_we",   32'(we),  32'h0);
    check_val("x0_pend", pending,  32'h0);
    check_val("x0_err",  32'(err), 32'h0);

    // Set and clear of the same rd in one cycle
    ld_issue = 1'b1; ld_issue_rd = 5'd21;
    step();
    ld_issue = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd21; ld_data = 32'hC1;
    step();
    ld_valid = 1'b0;
    ld_issue = 1'b1; ld_issue_rd = 5'd21;
    step();
    ld_issue = 1'b0;
    check_val("setclr_addr", 32'(WriteAddr), 32'd21);
    check_val("setclr_pend", pending,        32'h0020_0000);
    check_val("setclr_err",  32'(err),       32'h0);

    // Hazards: ALU write to pending rd
    do_reset();
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1;
    step();
    alu_valid = 1'b0;
    check_val("haz_alu_err", 32'(err), 32'h1);
    step();
    step();
    check_val("haz_sticky", 32'(err), 32'h1);
    do_reset();
    check_val("haz_rst_err", 32'(err), 32'h0);

    // Hazards: double issue
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
    check_val("haz_iss1_err", 32'(err), 32'h0);
    step();
    ld_issue = 1'b0;
    check_val("haz_iss2_err", 32'(err), 32'h1);
    do_reset();

    // Hazards: load result for a register never issued
    ld_valid = 1'b1; ld_rd = 5'd15; ld_data = 32'h1;
    step();
    ld_valid = 1'b0;
    check_val("haz_push_err", 32'(err), 32'h1);
    do_reset();

    // Reset mid-operation
    ld_issue = 1'b1; ld_issue_rd = 5'd3;
    step();
    ld_issue_rd = 5'd4;
    step();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h7;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hD3;
    step();
    ld_rd = 5'd4; ld_data = 32'hD4;
    step();
    ld_valid = 1'b0;
    check_val("mid_rdy",  32'(ld_ready), 32'h0);
    check_val("mid_pend", pending,       32'h0000_0018);
    alu_valid = 1'b0;
    rst = 1'b1;
    step();
    check_val("mid_rst_we",   32'(we),       32'h0);
    check_val("mid_rst_pend", pending,       32'h0);
    check_val("mid_rst_rdy",  32'(ld_ready), 32'h1);
    rst = 1'b0;
    step();
    check_val("mid_flushed_we", 32'(we), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
